// File: rtl/prt_scaler_pkg.sv
// Shared types and constants for the bilinear scaler control agent:
// tap order, window select encoding, coefficient scale and FSM states.
package prt_scaler_pkg;

    localparam int N_TAPS     = 4;
    localparam int TAP_00     = 0;   // line0, col n
    localparam int TAP_01     = 1;   // line0, col n+1
    localparam int TAP_10     = 2;   // line1, col n
    localparam int TAP_11     = 3;   // line1, col n+1

    localparam logic [3:0]  SEL_L0_C0  = 4'd0;
    localparam logic [3:0]  SEL_L1_C0  = 4'd5;
    localparam int          P_COEF_SUM = 64;
    localparam int          P_FX_ONE   = 8;
    localparam logic [15:0] P_STEP_MAX = 16'h1000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SOL,
        ST_ACTIVE,
        ST_EOL
    } agnt_state_e;

    function automatic logic [7:0] bilin_w(input logic [3:0] a, input logic [3:0] b);
        return 8'(a) * 8'(b);
    endfunction

    function automatic logic step_bad(input logic [15:0] step);
        return (step == 16'd0) || (step > P_STEP_MAX);
    endfunction

endpackage

// File: rtl/prt_scaler_agnt_phase.sv
// Maps one output pixel's phase (window column + 3-bit fractions) to the
// four kernel tap selects and their bilinear weights.
module prt_scaler_agnt_phase
    import prt_scaler_pkg::*;
(
    input  logic [4:0]          ph_i,    // {column offset[1:0], fx[2:0]}
    input  logic [2:0]          fy_i,
    output logic [N_TAPS*4-1:0] sel_o,
    output logic [N_TAPS*8-1:0] coef_o
);

    logic [3:0] n;
    logic [3:0] fx;
    logic [3:0] fy;
    logic [3:0] gx;
    logic [3:0] gy;
    logic [7:0] c01;
    logic [7:0] c10;
    logic [7:0] c11;

    assign n  = {2'b00, ph_i[4:3]};
    assign fx = {1'b0, ph_i[2:0]};
    assign fy = {1'b0, fy_i};
    assign gx = 4'(P_FX_ONE) - fx;
    assign gy = 4'(P_FX_ONE) - fy;

    assign sel_o[TAP_00*4 +: 4] = SEL_L0_C0 + n;
    assign sel_o[TAP_01*4 +: 4] = SEL_L0_C0 + n + 4'd1;
    assign sel_o[TAP_10*4 +: 4] = SEL_L1_C0 + n;
    assign sel_o[TAP_11*4 +: 4] = SEL_L1_C0 + n + 4'd1;

    assign c01 = bilin_w(fx, gy);
    assign c10 = bilin_w(gx, fy);
    assign c11 = bilin_w(fx, fy);

    // The weights are a partition of unity, so the home tap takes the remainder.
    assign coef_o[TAP_00*8 +: 8] = 8'(P_COEF_SUM) - c01 - c10 - c11;
    assign coef_o[TAP_01*8 +: 8] = c01;
    assign coef_o[TAP_10*8 +: 8] = c10;
    assign coef_o[TAP_11*8 +: 8] = c11;

endmodule

// File: rtl/prt_scaler_agnt.sv
// Bilinear upscaler control agent: walks horizontal/vertical phase accumulators
// over the destination frame and drives tap selects, weights and window advance.
module prt_scaler_agnt
    import prt_scaler_pkg::*;
#(
    parameter int P_PPC  = 4,
    parameter int P_FRAC = 12
) (
    input  logic        CLK_IN,
    input  logic        RST_IN,
    input  logic        CFG_RUN_IN,
    input  logic [15:0] CFG_HSTEP_IN,
    input  logic [15:0] CFG_VSTEP_IN,
    input  logic [15:0] CFG_DST_CLKS_IN,
    input  logic [15:0] CFG_DST_H_IN,
    input  logic        SLW_RDY_IN,
    output logic        SLW_SOL_OUT,
    output logic [2:0]  SLW_SHIFT_OUT,
    output logic        LB_NXT_OUT,
    output logic        AGNT_DE_OUT,
    output logic [63:0] MUX_SEL_OUT,
    output logic [31:0] COEF_P0_OUT,
    output logic [31:0] COEF_P1_OUT,
    output logic [31:0] COEF_P2_OUT,
    output logic [31:0] COEF_P3_OUT,
    output logic        STA_BUSY_OUT,
    output logic        STA_DONE_OUT,
    output logic        STA_CFG_ERR_OUT
);

    localparam int LW_P   = P_FRAC + 2;
    localparam int LW_N   = P_FRAC + 3;
    localparam int LW_SEL = P_PPC * N_TAPS * 4;
    localparam int LW_COF = P_PPC * N_TAPS * 8;
    localparam logic [P_FRAC:0] STEP_ONE = {1'b1, {P_FRAC{1'b0}}};

    agnt_state_e       state_q, state_d;
    logic [P_FRAC:0]   hstep_q, hstep_d;
    logic [P_FRAC:0]   vstep_q, vstep_d;
    logic [15:0]       dst_clks_q, dst_clks_d;
    logic [15:0]       dst_h_q, dst_h_d;
    logic              cfg_err_q, cfg_err_d;
    logic [P_FRAC-1:0] hbase_q, hbase_d;
    logic [P_FRAC-1:0] vacc_q, vacc_d;
    logic [15:0]       clk_cnt_q, clk_cnt_d;
    logic [15:0]       line_cnt_q, line_cnt_d;
    logic [LW_SEL-1:0] sel_hold_q, sel_hold_d;
    logic [LW_COF-1:0] coef_hold_q, coef_hold_d;

    logic [LW_SEL-1:0] sel_w;
    logic [LW_COF-1:0] coef_w;
    logic [LW_COF-1:0] coef_out;
    logic [LW_N-1:0]   nxt;
    logic [P_FRAC:0]   vnxt;
    logic              de, sol, lb_nxt, done;
    logic [2:0]        shift;

    genvar gi;
    generate
        for (gi = 0; gi < P_PPC; gi++) begin : g_pix
            logic [4:0] ph;
            assign ph = 5'(({2'b00, hbase_q} + LW_P'(gi) * {1'b0, hstep_q}) >> (P_FRAC - 3));

            prt_scaler_agnt_phase u_phase (
                .ph_i   (ph),
                .fy_i   (vacc_q[P_FRAC-1 -: 3]),
                .sel_o  (sel_w[gi*N_TAPS*4 +: N_TAPS*4]),
                .coef_o (coef_w[gi*N_TAPS*8 +: N_TAPS*8])
            );
        end
    endgenerate

    assign nxt  = {3'b000, hbase_q} + LW_N'(P_PPC) * {2'b00, hstep_q};
    assign vnxt = {1'b0, vacc_q} + vstep_q;

    always_comb begin
        state_d     = state_q;
        hstep_d     = hstep_q;
        vstep_d     = vstep_q;
        dst_clks_d  = dst_clks_q;
        dst_h_d     = dst_h_q;
        cfg_err_d   = cfg_err_q;
        hbase_d     = hbase_q;
        vacc_d      = vacc_q;
        clk_cnt_d   = clk_cnt_q;
        line_cnt_d  = line_cnt_q;
        sel_hold_d  = sel_hold_q;
        coef_hold_d = coef_hold_q;
        de          = 1'b0;
        sol         = 1'b0;
        lb_nxt      = 1'b0;
        done        = 1'b0;
        shift       = 3'd0;
        case (state_q)
            ST_IDLE: begin
                if (CFG_RUN_IN) begin
                    state_d    = ST_SOL;
                    hstep_d    = step_bad(CFG_HSTEP_IN) ? STEP_ONE : CFG_HSTEP_IN[P_FRAC:0];
                    vstep_d    = step_bad(CFG_VSTEP_IN) ? STEP_ONE : CFG_VSTEP_IN[P_FRAC:0];
                    cfg_err_d  = step_bad(CFG_HSTEP_IN) || step_bad(CFG_VSTEP_IN);
                    dst_clks_d = (CFG_DST_CLKS_IN == 16'd0) ? 16'd1 : CFG_DST_CLKS_IN;
                    dst_h_d    = (CFG_DST_H_IN == 16'd0) ? 16'd1 : CFG_DST_H_IN;
                    vacc_d     = '0;
                    line_cnt_d = '0;
                end
            end
            ST_SOL: begin
                sol       = 1'b1;
                hbase_d   = '0;
                clk_cnt_d = '0;
                state_d   = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                // A stalled window freezes the walk; nothing advances until RDY returns.
                if (SLW_RDY_IN) begin
                    de          = 1'b1;
                    shift       = nxt[LW_N-1:P_FRAC];
                    hbase_d     = nxt[P_FRAC-1:0];
                    sel_hold_d  = sel_w;
                    coef_hold_d = coef_w;
                    if (clk_cnt_q == dst_clks_q - 16'd1) begin
                        clk_cnt_d = '0;
                        state_d   = ST_EOL;
                    end else begin
                        clk_cnt_d = clk_cnt_q + 16'd1;
                    end
                end
            end
            ST_EOL: begin
                lb_nxt     = vnxt[P_FRAC];
                vacc_d     = vnxt[P_FRAC-1:0];
                line_cnt_d = line_cnt_q + 16'd1;
                state_d    = ST_SOL;
                if (line_cnt_q == dst_h_q - 16'd1) begin
                    done       = 1'b1;
                    vacc_d     = '0;
                    line_cnt_d = '0;
                    if (CFG_RUN_IN) begin
                        cfg_err_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RST_IN) begin
        if (!RST_IN) begin
            state_q     <= ST_IDLE;
            hstep_q     <= '0;
            vstep_q     <= '0;
            dst_clks_q  <= '0;
            dst_h_q     <= '0;
            cfg_err_q   <= 1'b0;
            hbase_q     <= '0;
            vacc_q      <= '0;
            clk_cnt_q   <= '0;
            line_cnt_q  <= '0;
            sel_hold_q  <= '0;
            coef_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            hstep_q     <= hstep_d;
            vstep_q     <= vstep_d;
            dst_clks_q  <= dst_clks_d;
            dst_h_q     <= dst_h_d;
            cfg_err_q   <= cfg_err_d;
            hbase_q     <= hbase_d;
            vacc_q      <= vacc_d;
            clk_cnt_q   <= clk_cnt_d;
            line_cnt_q  <= line_cnt_d;
            sel_hold_q  <= sel_hold_d;
            coef_hold_q <= coef_hold_d;
        end
    end

    // Selects/weights track the live window only while DE is high; otherwise hold.
    assign coef_out        = de ? coef_w : coef_hold_q;
    assign MUX_SEL_OUT     = de ? sel_w : sel_hold_q;
    assign COEF_P0_OUT     = coef_out[0*32 +: 32];
    assign COEF_P1_OUT     = coef_out[1*32 +: 32];
    assign COEF_P2_OUT     = coef_out[2*32 +: 32];
    assign COEF_P3_OUT     = coef_out[3*32 +: 32];
    assign AGNT_DE_OUT     = de;
    assign SLW_SOL_OUT     = sol;
    assign SLW_SHIFT_OUT   = shift;
    assign LB_NXT_OUT      = lb_nxt;
    assign STA_DONE_OUT    = done;
    assign STA_BUSY_OUT    = (state_q != ST_IDLE);
    assign STA_CFG_ERR_OUT = cfg_err_q;

endmodule

// File: tb/tb_prt_scaler_agnt.sv
// Randomised bench for prt_scaler_agnt: absolute source positions (pixel index
// times step) give the expected taps, weights, shifts and line advances.
module tb_prt_scaler_agnt;

    logic        clk, rst_n, run, rdy;
    logic [15:0] hstep, vstep, dclks, dh;
    logic        sol, lb, de, busy, done, err;
    logic [2:0]  shift;
    logic [63:0] sel;
    logic [31:0] c0, c1, c2, c3;
    logic [127:0] coef_all;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          n_frame  = 0;
    logic [63:0]  last_sel;
    logic [127:0] last_coef;
    bit           exp_err;

    assign coef_all = {c3, c2, c1, c0};

    prt_scaler_agnt dut (
        .CLK_IN          (clk),
        .RST_IN          (rst_n),
        .CFG_RUN_IN      (run),
        .CFG_HSTEP_IN    (hstep),
        .CFG_VSTEP_IN    (vstep),
        .CFG_DST_CLKS_IN (dclks),
        .CFG_DST_H_IN    (dh),
        .SLW_RDY_IN      (rdy),
        .SLW_SOL_OUT     (sol),
        .SLW_SHIFT_OUT   (shift),
        .LB_NXT_OUT      (lb),
        .AGNT_DE_OUT     (de),
        .MUX_SEL_OUT     (sel),
        .COEF_P0_OUT     (c0),
        .COEF_P1_OUT     (c1),
        .COEF_P2_OUT     (c2),
        .COEF_P3_OUT     (c3),
        .STA_BUSY_OUT    (busy),
        .STA_DONE_OUT    (done),
        .STA_CFG_ERR_OUT (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time %0t reached, expected end of test", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, expv);
        end
    endtask

    function automatic bit bad_step(input logic [15:0] s);
        return (s == 16'd0) || (s > 16'h1000);
    endfunction

    function automatic int eff_step(input logic [15:0] s);
        return bad_step(s) ? 4096 : int'(s);
    endfunction

    // Source position of dst pixel j is j*step; the window origin for clock x is floor(4x*step).
    function automatic void exp_pix(input int x, input int h_e, input int y, input int v_e,
                                    output logic [63:0] es, output logic [127:0] ec);
        longint base, p;
        int n, fx, fy;
        es = '0;
        ec = '0;
        base = (longint'(4 * x) * h_e) / 4096;
        fy = int'(((longint'(y) * v_e) % 4096) / 512);
        for (int k = 0; k < 4; k++) begin
            p  = longint'(4 * x + k) * h_e;
            n  = int'(p / 4096 - base);
            fx = int'((p % 4096) / 512);
            es[(4*k+0)*4 +: 4] = 4'(n);
            es[(4*k+1)*4 +: 4] = 4'(n + 1);
            es[(4*k+2)*4 +: 4] = 4'(5 + n);
            es[(4*k+3)*4 +: 4] = 4'(6 + n);
            ec[k*32 +  0 +: 8] = 8'((8 - fx) * (8 - fy));
            ec[k*32 +  8 +: 8] = 8'(fx * (8 - fy));
            ec[k*32 + 16 +: 8] = 8'((8 - fx) * fy);
            ec[k*32 + 24 +: 8] = 8'(fx * fy);
        end
    endfunction

    task automatic chk_ctl(input string ph, input bit e_sol, input bit e_de, input int e_shift,
                           input bit e_lb, input bit e_done, input bit e_busy, input bit e_err);
        chk({ph, ".sol"},   sol,   64'(e_sol));
        chk({ph, ".de"},    de,    64'(e_de));
        chk({ph, ".shift"}, shift, 64'(e_shift));
        chk({ph, ".lb"},    lb,    64'(e_lb));
        chk({ph, ".done"},  done,  64'(e_done));
        chk({ph, ".busy"},  busy,  64'(e_busy));
        chk({ph, ".err"},   err,   64'(e_err));
    endtask

    task automatic chk_vals(input string ph, input logic [63:0] es, input logic [127:0] ec);
        chk({ph, ".sel"},     sel,             es);
        chk({ph, ".coef_lo"}, coef_all[63:0],  ec[63:0]);
        chk({ph, ".coef_hi"}, coef_all[127:64], ec[127:64]);
    endtask

    // Entered and left on a falling edge; one loop pass per DUT clock.
    task automatic run_frame(input logic [15:0] hs, input logic [15:0] vs, input logic [15:0] clks,
                             input logic [15:0] lines, input int stall_pct, input bit from_idle,
                             input bit hold_run, input int fix_x, input int fix_n);
        int eh, ev, ns, eshift;
        logic [63:0]  es;
        logic [127:0] ec;
        bit elb;
        eh = eff_step(hs);
        ev = eff_step(vs);
        n_frame++;
        $display("frame %0d: hstep=%h vstep=%h clks=%0d lines=%0d stall=%0d%% run_held=%0d",
                 n_frame, hs, vs, clks, lines, stall_pct, hold_run);
        if (from_idle) begin
            hstep = hs; vstep = vs; dclks = clks; dh = lines;
            run = 1'b1; rdy = 1'b0;
            #1;
            chk("idle.busy", busy, 64'd0);
            @(negedge clk);
            exp_err = bad_step(hs) || bad_step(vs);
        end else begin
            exp_err = 1'b0;
        end
        run = hold_run;
        for (int y = 0; y < int'(lines); y++) begin
            rdy = 1'($urandom_range(0, 1));
            #1;
            chk_ctl("sol", 1, 0, 0, 0, 0, 1, exp_err);
            chk_vals("sol", last_sel, last_coef);
            @(negedge clk);
            for (int x = 0; x < int'(clks); x++) begin
                if (x == fix_x) ns = fix_n;
                else if (stall_pct > 0 && int'($urandom_range(0, 99)) < stall_pct) ns = int'($urandom_range(1, 3));
                else ns = 0;
                repeat (ns) begin
                    rdy = 1'b0;
                    #1;
                    chk_ctl("stall", 0, 0, 0, 0, 0, 1, exp_err);
                    chk_vals("stall", last_sel, last_coef);
                    @(negedge clk);
                end
                rdy = 1'b1;
                #1;
                exp_pix(x, eh, y, ev, es, ec);
                eshift = int'((longint'(4 * (x + 1)) * eh) / 4096 - (longint'(4 * x) * eh) / 4096);
                chk_ctl("act", 0, 1, eshift, 0, 0, 1, exp_err);
                chk_vals("act", es, ec);
                last_sel  = es;
                last_coef = ec;
                @(negedge clk);
            end
            rdy = 1'($urandom_range(0, 1));
            #1;
            elb = ((y + 1) * ev) / 4096 != (y * ev) / 4096;
            chk_ctl("eol", 0, 0, 0, elb, (y == int'(lines) - 1), 1, exp_err);
            chk_vals("eol", last_sel, last_coef);
            @(negedge clk);
        end
        if (!hold_run) begin
            #1;
            chk_ctl("idle", 0, 0, 0, 0, 0, 0, exp_err);
            chk_vals("idle", last_sel, last_coef);
        end
    endtask

    initial begin
        rst_n = 1'b1; run = 1'b0; rdy = 1'b0;
        hstep = 16'h1000; vstep = 16'h1000; dclks = 16'd1; dh = 16'd1;
        last_sel = '0; last_coef = '0; exp_err = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk_ctl("rst", 0, 0, 0, 0, 0, 0, 0);
        chk_vals("rst", 64'd0, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_frame(16'h1000, 16'h1000, 16'd4, 16'd2, 0, 1, 0, -1, 0);
        run_frame(16'h0800, 16'h0800, 16'd3, 16'd4, 0, 1, 0, -1, 0);
        run_frame(16'h0600, 16'h0a00, 16'd4, 16'd2, 0, 1, 0, 2, 3);
        run_frame(16'h0000, 16'h1000, 16'd2, 16'd2, 0, 1, 0, -1, 0);
        run_frame(16'h0c00, 16'h0400, 16'd2, 16'd1, 0, 1, 0, -1, 0);
        run_frame(16'h1000, 16'h1000, 16'd1, 16'd1, 0, 1, 1, -1, 0);
        run_frame(16'h1000, 16'h1000, 16'd1, 16'd1, 0, 0, 1, -1, 0);
        run_frame(16'h1000, 16'h1000, 16'd1, 16'd1, 0, 0, 0, -1, 0);

        for (int i = 0; i < 12; i++) begin
            logic [15:0] hs, vs;
            hs = ($urandom_range(0, 9) == 0) ? 16'(($urandom_range(0, 1) == 0) ? 0 : 16'h1001 + $urandom_range(0, 100))
                                             : 16'($urandom_range(1, 4096));
            vs = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom_range(1, 4096));
            run_frame(hs, vs, 16'($urandom_range(1, 5)), 16'($urandom_range(1, 4)), 30, 1, 0, -1, 0);
        end

        // Reset in the middle of an active line.
        hstep = 16'h0400; vstep = 16'h0400; dclks = 16'd4; dh = 16'd2;
        run = 1'b1; rdy = 1'b0;
        @(negedge clk);
        run = 1'b0; rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("midline.de", de, 64'd1);
        rst_n = 1'b0;
        #1;
        last_sel = '0; last_coef = '0; exp_err = 1'b0;
        chk_ctl("midrst", 0, 0, 0, 0, 0, 0, 0);
        chk_vals("midrst", 64'd0, 128'd0);
        @(negedge clk);
        rst_n = 1'b1; rdy = 1'b0;
        @(negedge clk);
        #1;
        chk_ctl("postrst", 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        run_frame(16'h0555, 16'h0700, 16'd3, 16'd3, 20, 1, 0, -1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
